// File: rtl/rv32_types.sv
// Shared types for the rv32 pipeline control unit: the FSM state encoding
// and the per-stage hold/flush/bubble control bundle.
package rv32_types;

    typedef enum logic [1:0] {
        START     = 2'd0,
        RUN       = 2'd1,
        EXEC_WAIT = 2'd2,
        MEM_WAIT  = 2'd3
    } ctrl_state_t;

    typedef struct packed {
        logic hold_f;
        logic hold_d;
        logic hold_e;
        logic hold_m;
        logic flush_d;
        logic bubble_e;
        logic bubble_m;
        logic bubble_w;
    } pipe_ctrl_t;

    // Width of the memory-wait watchdog counter; covers the full MEM_TIMEOUT range.
    localparam int WAIT_W = 16;

    localparam pipe_ctrl_t CTRL_IDLE   = pipe_ctrl_t'(8'b0000_0000);
    localparam pipe_ctrl_t CTRL_START  = pipe_ctrl_t'(8'b1000_0100);
    localparam pipe_ctrl_t CTRL_HAZARD = pipe_ctrl_t'(8'b1100_0100);
    localparam pipe_ctrl_t CTRL_BRANCH = pipe_ctrl_t'(8'b0000_1100);
    localparam pipe_ctrl_t CTRL_EXEC   = pipe_ctrl_t'(8'b1110_0010);
    localparam pipe_ctrl_t CTRL_MEM    = pipe_ctrl_t'(8'b1111_0001);

endpackage

// File: rtl/rv32_perf_counter.sv
// Free-running event counter: increments on inc, wraps modulo 2^CNT_W.
module rv32_perf_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count <= '0;
        end else if (inc) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/rv32_pipeline_control_unit.sv
// Stall/flush sequencer for the 5-stage rv32 pipeline: turns hazard, branch,
// multi-cycle exec and data-memory handshakes into per-stage hold/bubble controls.
module rv32_pipeline_control_unit
    import rv32_types::*;
#(
    parameter int unsigned MEM_TIMEOUT = 256,
    parameter int          CNT_W       = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             hazard_stall,
    input  logic             branch_taken,
    input  logic             exec_start,
    input  logic             exec_done,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             hold_f,
    output logic             hold_d,
    output logic             hold_e,
    output logic             hold_m,
    output logic             flush_d,
    output logic             bubble_e,
    output logic             bubble_m,
    output logic             bubble_w,
    output logic [1:0]       ctrl_state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             mem_timeout_err
);

    localparam logic [WAIT_W-1:0] TIMEOUT_VAL = WAIT_W'(MEM_TIMEOUT);

    ctrl_state_t       state_q, state_d;
    logic              ret_exec_q, ret_exec_d;
    logic              pend_q, pend_d;
    logic [WAIT_W-1:0] wait_q, wait_next;
    logic              err_q;
    pipe_ctrl_t        ctrl;

    logic mem_hold;
    logic in_exec;
    logic exec_finish;

    assign mem_hold    = mem_req & ~mem_ready;
    // The release cycle of a memory wait taken from EXEC_WAIT still holds E;
    // a done (or pending done) is only consumed once EXEC_WAIT is re-entered.
    assign in_exec     = (state_q == EXEC_WAIT) | ((state_q == MEM_WAIT) & ret_exec_q);
    assign exec_finish = (state_q == EXEC_WAIT) & (exec_done | pend_q);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= START;
            ret_exec_q <= 1'b0;
            pend_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ret_exec_q <= ret_exec_d;
            pend_q     <= pend_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ret_exec_d = ret_exec_q;
        pend_d     = pend_q;
        case (state_q)
            START: state_d = RUN;
            RUN: begin
                if (mem_hold) begin
                    state_d    = MEM_WAIT;
                    ret_exec_d = exec_start;
                end else if (exec_start) begin
                    state_d = EXEC_WAIT;
                end
            end
            EXEC_WAIT: begin
                if (mem_hold) begin
                    state_d    = MEM_WAIT;
                    ret_exec_d = 1'b1;
                    pend_d     = pend_q | exec_done;
                end else if (exec_finish) begin
                    state_d = RUN;
                    pend_d  = 1'b0;
                end
            end
            MEM_WAIT: begin
                pend_d = pend_q | (exec_done & ret_exec_q);
                if (!mem_hold) begin
                    if (ret_exec_q || exec_start) state_d = EXEC_WAIT;
                    else                          state_d = RUN;
                end
            end
            default: state_d = START;
        endcase
    end

    always_comb begin
        ctrl = CTRL_IDLE;
        if (state_q == START) begin
            ctrl = CTRL_START;
        end else if (mem_hold) begin
            ctrl = CTRL_MEM;
        end else if (in_exec) begin
            if (!exec_finish)      ctrl = CTRL_EXEC;
            else if (branch_taken) ctrl = CTRL_BRANCH;
        end else if (exec_start) begin
            ctrl = CTRL_EXEC;
        end else if (branch_taken) begin
            ctrl = CTRL_BRANCH;
        end else if (hazard_stall) begin
            ctrl = CTRL_HAZARD;
        end
    end

    assign wait_next = (wait_q == '1) ? wait_q : wait_q + WAIT_W'(1);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wait_q <= '0;
            err_q  <= 1'b0;
        end else if (mem_hold && (state_q != START)) begin
            wait_q <= wait_next;
            if (wait_next >= TIMEOUT_VAL) err_q <= 1'b1;
        end else begin
            wait_q <= '0;
        end
    end

    rv32_perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk    (clk),
        .resetn (resetn),
        .inc    (ctrl.hold_f),
        .count  (stall_cnt)
    );

    rv32_perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk    (clk),
        .resetn (resetn),
        .inc    (ctrl.flush_d),
        .count  (flush_cnt)
    );

    assign {hold_f, hold_d, hold_e, hold_m, flush_d, bubble_e, bubble_m, bubble_w} = ctrl;
    assign ctrl_state      = state_q;
    assign mem_timeout_err = err_q;

    // A second start while one op is outstanding is a protocol violation.
    exec_start_in_wait: assert property (
        @(posedge clk) disable iff (!resetn) !((state_q == EXEC_WAIT) && exec_start));

endmodule

// File: tb/tb_rv32_pipeline_control_unit.sv
// Scenario bench for rv32_pipeline_control_unit: per-cycle expected state and
// control bits go through a queue and are compared at the falling edge.
module tb_rv32_pipeline_control_unit;

    localparam int CNT_W = 8;

    // stimulus order: {hazard_stall, branch_taken, exec_start, exec_done, mem_req, mem_ready}
    localparam logic [5:0] I_NONE     = 6'b000000;
    localparam logic [5:0] I_HAZ      = 6'b100000;
    localparam logic [5:0] I_BR       = 6'b010000;
    localparam logic [5:0] I_HB       = 6'b110000;
    localparam logic [5:0] I_START    = 6'b001000;
    localparam logic [5:0] I_DONE     = 6'b000100;
    localparam logic [5:0] I_DB       = 6'b010100;
    localparam logic [5:0] I_REQ      = 6'b000010;
    localparam logic [5:0] I_REQ_DONE = 6'b000110;
    localparam logic [5:0] I_REQ_RDY  = 6'b000011;

    localparam logic [1:0] S_START = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_EW    = 2'd2;
    localparam logic [1:0] S_MW    = 2'd3;

    // {hold_f, hold_d, hold_e, hold_m, flush_d, bubble_e, bubble_m, bubble_w}
    localparam logic [7:0] C_Z     = 8'b0000_0000;
    localparam logic [7:0] C_START = 8'b1000_0100;
    localparam logic [7:0] C_HZ    = 8'b1100_0100;
    localparam logic [7:0] C_BR    = 8'b0000_1100;
    localparam logic [7:0] C_EX    = 8'b1110_0010;
    localparam logic [7:0] C_MH    = 8'b1111_0001;

    logic clk = 1'b0;
    logic resetn;
    logic hazard_stall, branch_taken, exec_start, exec_done, mem_req, mem_ready;
    logic hold_f, hold_d, hold_e, hold_m, flush_d, bubble_e, bubble_m, bubble_w;
    logic [1:0]       ctrl_state;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic             mem_timeout_err;

    logic [9:0] obs;
    logic [9:0] exp_q[$];
    logic [9:0] exp_v;
    logic [CNT_W-1:0] exp_stall, exp_flush;
    int n_checks = 0;
    int n_fail   = 0;

    assign obs = {ctrl_state, hold_f, hold_d, hold_e, hold_m, flush_d, bubble_e, bubble_m, bubble_w};

    rv32_pipeline_control_unit #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .hazard_stall    (hazard_stall),
        .branch_taken    (branch_taken),
        .exec_start      (exec_start),
        .exec_done       (exec_done),
        .mem_req         (mem_req),
        .mem_ready       (mem_ready),
        .hold_f          (hold_f),
        .hold_d          (hold_d),
        .hold_e          (hold_e),
        .hold_m          (hold_m),
        .flush_d         (flush_d),
        .bubble_e        (bubble_e),
        .bubble_m        (bubble_m),
        .bubble_w        (bubble_w),
        .ctrl_state      (ctrl_state),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt),
        .mem_timeout_err (mem_timeout_err)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs just after the rising edge, record what that
    // cycle must produce, and stop at the falling edge for sampling.
    task automatic apply(input logic [5:0] stim, input logic [9:0] want);
        @(posedge clk);
        #1;
        {hazard_stall, branch_taken, exec_start, exec_done, mem_req, mem_ready} = stim;
        exp_q.push_back(want);
        exp_stall = exp_stall + {{(CNT_W-1){1'b0}}, want[7]};
        exp_flush = exp_flush + {{(CNT_W-1){1'b0}}, want[3]};
        @(negedge clk);
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        {hazard_stall, branch_taken, exec_start, exec_done, mem_req, mem_ready} = I_NONE;
        exp_stall = '0;
        exp_flush = '0;
        repeat (2) @(negedge clk);
        n_checks += 4;
        if (obs !== {S_START, C_START}) begin n_fail++; $display("FAIL reset_state: got %b expected %b", obs, {S_START, C_START}); end
        if (stall_cnt !== '0) begin n_fail++; $display("FAIL reset_stall_cnt: got %0d expected 0", stall_cnt); end
        if (flush_cnt !== '0) begin n_fail++; $display("FAIL reset_flush_cnt: got %0d expected 0", flush_cnt); end
        if (mem_timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", mem_timeout_err); end
        resetn = 1'b1;
        #1;
        n_checks++;
        if (obs !== {S_START, C_START}) begin n_fail++; $display("FAIL start_cycle: got %b expected %b", obs, {S_START, C_START}); end
        exp_stall = 1;
        apply(I_NONE, {S_RUN, C_Z});
        exp_v = exp_q.pop_front();
        n_checks += 2;
        if (obs !== exp_v) begin n_fail++; $display("FAIL first_run: got %b expected %b", obs, exp_v); end
        if (stall_cnt !== exp_stall) begin n_fail++; $display("FAIL start_stall_cnt: got %0d expected %0d", stall_cnt, exp_stall); end
    endtask

    task automatic test_hazard();
        logic [5:0] stim [2] = '{I_HAZ, I_NONE};
        logic [9:0] want [2] = '{{S_RUN, C_HZ}, {S_RUN, C_Z}};
        for (int i = 0; i < 2; i++) begin
            apply(stim[i], want[i]);
            exp_v = exp_q.pop_front();
            n_checks++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL hazard[%0d]: got %b expected %b", i, obs, exp_v); end
        end
        n_checks++;
        if (stall_cnt !== exp_stall) begin n_fail++; $display("FAIL hazard_stall_cnt: got %0d expected %0d", stall_cnt, exp_stall); end
    endtask

    task automatic test_branch();
        logic [5:0] stim [4] = '{I_HB, I_BR, I_HAZ, I_NONE};
        logic [9:0] want [4] = '{{S_RUN, C_BR}, {S_RUN, C_BR}, {S_RUN, C_HZ}, {S_RUN, C_Z}};
        for (int i = 0; i < 4; i++) begin
            apply(stim[i], want[i]);
            exp_v = exp_q.pop_front();
            n_checks++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL branch[%0d]: got %b expected %b", i, obs, exp_v); end
        end
        n_checks += 2;
        if (flush_cnt !== exp_flush) begin n_fail++; $display("FAIL branch_flush_cnt: got %0d expected %0d", flush_cnt, exp_flush); end
        if (stall_cnt !== exp_stall) begin n_fail++; $display("FAIL branch_stall_cnt: got %0d expected %0d", stall_cnt, exp_stall); end
    endtask

    task automatic test_exec();
        logic [5:0] stim [7] = '{I_START, I_NONE, I_NONE, I_NONE, I_NONE, I_DONE, I_NONE};
        logic [9:0] want [7] = '{{S_RUN, C_EX}, {S_EW, C_EX}, {S_EW, C_EX}, {S_EW, C_EX},
                                 {S_EW, C_EX}, {S_EW, C_Z}, {S_RUN, C_Z}};
        for (int i = 0; i < 7; i++) begin
            apply(stim[i], want[i]);
            exp_v = exp_q.pop_front();
            n_checks++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL exec[%0d]: got %b expected %b", i, obs, exp_v); end
        end
        n_checks++;
        if (stall_cnt !== exp_stall) begin n_fail++; $display("FAIL exec_stall_cnt: got %0d expected %0d", stall_cnt, exp_stall); end
    endtask

    task automatic test_exec_branch();
        logic [5:0] stim [5] = '{I_START, I_HAZ, I_BR, I_DB, I_NONE};
        logic [9:0] want [5] = '{{S_RUN, C_EX}, {S_EW, C_EX}, {S_EW, C_EX}, {S_EW, C_BR}, {S_RUN, C_Z}};
        for (int i = 0; i < 5; i++) begin
            apply(stim[i], want[i]);
            exp_v = exp_q.pop_front();
            n_checks++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL exec_branch[%0d]: got %b expected %b", i, obs, exp_v); end
        end
        n_checks++;
        if (flush_cnt !== exp_flush) begin n_fail++; $display("FAIL exec_branch_flush_cnt: got %0d expected %0d", flush_cnt, exp_flush); end
    endtask

    task automatic test_mem_in_exec();
        logic [5:0] stim [8] = '{I_START, I_NONE, I_REQ, I_REQ_DONE, I_REQ, I_REQ_RDY, I_NONE, I_NONE};
        logic [9:0] want [8] = '{{S_RUN, C_EX}, {S_EW, C_EX}, {S_EW, C_MH}, {S_MW, C_MH},
                                 {S_MW, C_MH}, {S_MW, C_EX}, {S_EW, C_Z}, {S_RUN, C_Z}};
        for (int i = 0; i < 8; i++) begin
            apply(stim[i], want[i]);
            exp_v = exp_q.pop_front();
            n_checks++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL mem_in_exec[%0d]: got %b expected %b", i, obs, exp_v); end
        end
        n_checks += 2;
        if (mem_timeout_err !== 1'b0) begin n_fail++; $display("FAIL mem_short_err: got %b expected 0", mem_timeout_err); end
        if (stall_cnt !== exp_stall) begin n_fail++; $display("FAIL mem_in_exec_stall_cnt: got %0d expected %0d", stall_cnt, exp_stall); end
    endtask

    task automatic test_counter_wrap();
        int n;
        n = (1 << CNT_W) - int'(exp_stall) + 3;
        for (int i = 0; i < n; i++) begin
            apply(I_HAZ, {S_RUN, C_HZ});
            exp_v = exp_q.pop_front();
            n_checks++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL wrap_cycle[%0d]: got %b expected %b", i, obs, exp_v); end
        end
        apply(I_NONE, {S_RUN, C_Z});
        exp_v = exp_q.pop_front();
        n_checks += 2;
        if (obs !== exp_v) begin n_fail++; $display("FAIL wrap_idle: got %b expected %b", obs, exp_v); end
        if (stall_cnt !== exp_stall) begin n_fail++; $display("FAIL wrap_stall_cnt: got %0d expected %0d", stall_cnt, exp_stall); end
    endtask

    task automatic test_mem_timeout();
        logic [5:0] stim [8] = '{I_REQ, I_REQ, I_REQ, I_REQ, I_REQ, I_REQ, I_REQ_RDY, I_NONE};
        logic [9:0] want [8] = '{{S_RUN, C_MH}, {S_MW, C_MH}, {S_MW, C_MH}, {S_MW, C_MH},
                                 {S_MW, C_MH}, {S_MW, C_MH}, {S_MW, C_Z}, {S_RUN, C_Z}};
        logic err_want;
        for (int i = 0; i < 8; i++) begin
            apply(stim[i], want[i]);
            exp_v = exp_q.pop_front();
            err_want = (i >= 4);
            n_checks += 2;
            if (obs !== exp_v) begin n_fail++; $display("FAIL timeout[%0d]: got %b expected %b", i, obs, exp_v); end
            if (mem_timeout_err !== err_want) begin n_fail++; $display("FAIL timeout_err[%0d]: got %b expected %b", i, mem_timeout_err, err_want); end
        end
        n_checks += 2;
        if (stall_cnt !== exp_stall) begin n_fail++; $display("FAIL timeout_stall_cnt: got %0d expected %0d", stall_cnt, exp_stall); end
        if (flush_cnt !== exp_flush) begin n_fail++; $display("FAIL timeout_flush_cnt: got %0d expected %0d", flush_cnt, exp_flush); end
    endtask

    task automatic test_reset_mid();
        apply(I_REQ, {S_RUN, C_MH});
        exp_v = exp_q.pop_front();
        n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL mid_pre: got %b expected %b", obs, exp_v); end
        @(posedge clk);
        #3;
        resetn = 1'b0;
        {hazard_stall, branch_taken, exec_start, exec_done, mem_req, mem_ready} = I_NONE;
        #1;
        n_checks += 4;
        if (obs !== {S_START, C_START}) begin n_fail++; $display("FAIL mid_reset_state: got %b expected %b", obs, {S_START, C_START}); end
        if (mem_timeout_err !== 1'b0) begin n_fail++; $display("FAIL mid_reset_err: got %b expected 0", mem_timeout_err); end
        if (stall_cnt !== '0) begin n_fail++; $display("FAIL mid_reset_stall_cnt: got %0d expected 0", stall_cnt); end
        if (flush_cnt !== '0) begin n_fail++; $display("FAIL mid_reset_flush_cnt: got %0d expected 0", flush_cnt); end
        exp_q.delete();
        exp_flush = '0;
        @(negedge clk);
        resetn = 1'b1;
        exp_stall = 1;
        apply(I_NONE, {S_RUN, C_Z});
        exp_v = exp_q.pop_front();
        n_checks += 3;
        if (obs !== exp_v) begin n_fail++; $display("FAIL mid_restart: got %b expected %b", obs, exp_v); end
        if (stall_cnt !== exp_stall) begin n_fail++; $display("FAIL mid_restart_stall_cnt: got %0d expected %0d", stall_cnt, exp_stall); end
        if (mem_timeout_err !== 1'b0) begin n_fail++; $display("FAIL mid_restart_err: got %b expected 0", mem_timeout_err); end
    endtask

    initial begin
        test_reset();
        test_hazard();
        test_branch();
        test_exec();
        test_exec_branch();
        test_mem_in_exec();
        test_counter_wrap();
        test_mem_timeout();
        test_reset_mid();
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL leftover_expected: got %0d entries expected 0", exp_q.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached before the scenarios completed");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rv32_pipeline_control_unit.md
Name: rv32_pipeline_control_unit

Overview:
Central stall/flush sequencer for the 5-stage rv32 core (F, D, E, M, W). Takes the decode-stage hazard stall, branch redirect from exec, multi-cycle exec unit handshake and data-memory handshake. Produces per-stage hold and bubble/flush controls each cycle. Keeps a small FSM plus stall and flush performance counters and a memory-wait watchdog.

Parameters:
MEM_TIMEOUT, 256, consecutive MEM_WAIT cycles before mem_timeout_err sets (range 2..65535).
CNT_W, 32, width of performance counters.

Ports:
clk  in  1  core clock
resetn  in  1  asynchronous active-low reset
hazard_stall  in  1  load-use stall from decode hazard detection
branch_taken  in  1  E-stage instruction redirects PC
exec_start  in  1  E-stage instruction starts a multi-cycle op (1-cycle pulse per op)
exec_done  in  1  multi-cycle op result valid (1-cycle pulse)
mem_req  in  1  M-stage instruction issues a data access
mem_ready  in  1  data memory accepts/completes the access this cycle
hold_f  out  1  hold PC / fetch_decode buffer
hold_d  out  1  hold decode_exec buffer input side
hold_e  out  1  hold exec_mem buffer
hold_m  out  1  hold mem_wb buffer
flush_d  out  1  replace fetch_decode buffer contents with NOP
bubble_e  out  1  load NOP into decode_exec buffer
bubble_m  out  1  load NOP into exec_mem buffer
bubble_w  out  1  load NOP into mem_wb buffer
ctrl_state  out  2  current FSM state (debug)
stall_cnt  out  CNT_W  cycles with hold_f=1
flush_cnt  out  CNT_W  accepted branch redirects
mem_timeout_err  out  1  sticky watchdog flag

Behaviour:
- All control outputs are combinational from the registered state and current inputs. Counters and flags are registered.
- Reset: state=START; stall_cnt=0, flush_cnt=0, mem_timeout_err=0, internal wait counter=0, exec_done_pend=0.
- States: START, RUN, EXEC_WAIT, MEM_WAIT.
- START: one cycle. hold_f=1, bubble_e=1, all other controls 0. Next state is always RUN.
- Combinational mem_hold = mem_req & ~mem_ready.
- Priority, highest first: mem_hold > EXEC_WAIT/exec_start > branch_taken > hazard_stall.
- mem_hold, in any state except START: hold_f=hold_d=hold_e=hold_m=1, bubble_w=1, all other controls 0.
  - State becomes MEM_WAIT, remembering the return state (RUN or EXEC_WAIT).
  - Wait counter increments, saturating. When it reaches MEM_TIMEOUT, mem_timeout_err sets (sticky). Stalls continue regardless.
- MEM_WAIT with ~mem_hold: return to the remembered state and clear the wait counter.
- exec_done arriving while in MEM_WAIT sets exec_done_pend. Re-entering EXEC_WAIT with exec_done_pend=1 treats it as exec_done that cycle and clears it.
- exec_start in RUN without mem_hold: go to EXEC_WAIT. That cycle already has hold_f=hold_d=hold_e=1 and bubble_m=1.
- EXEC_WAIT: hold_f=hold_d=hold_e=1, bubble_m=1 every cycle until exec_done (or pend).
  - On the done cycle, all holds drop, E advances, and the next state is RUN.
  - A branch_taken on the done cycle is applied that cycle (flush_d=1, bubble_e=1).
- branch_taken in RUN, no mem_hold, no exec_start: flush_d=1, bubble_e=1, flush_cnt++. hazard_stall is ignored that cycle because the stalled D instruction is killed.
- A branch held under a stall is counted only in the cycle its flush is applied.
- hazard_stall alone in RUN: hold_f=hold_d=1, bubble_e=1.
- stall_cnt increments on every cycle hold_f=1, START included. Both counters wrap modulo 2^CNT_W.
- exec_start while already in EXEC_WAIT is ignored (protocol violation, asserted in simulation).
- resetn low mid-operation: immediate return to the reset values above. Pending exec/mem operations are abandoned.

Decomposition:
- rv32_types package gets:
  - pipe_ctrl_t, a packed struct of the 8 hold/flush/bubble bits;
  - ctrl_state_t, a 2-bit enum {START=0, RUN=1, EXEC_WAIT=2, MEM_WAIT=3}.
- Module exports ctrl as pipe_ctrl_t internally; ports stay flat.
- One natural sub-module, rv32_perf_counter: a CNT_W-bit counter with inc and wrap, instantiated twice for stall_cnt and flush_cnt.

Test Plan:
- Reset release, quiet inputs -> cycle 0 START: hold_f=1, bubble_e=1, stall_cnt becomes 1. Cycle 1 RUN with all controls 0.
- hazard_stall=1 for 1 cycle in RUN -> hold_f=hold_d=bubble_e=1 that cycle only. stall_cnt increases by 1.
- branch_taken and hazard_stall together in RUN -> flush_d=bubble_e=1, hold_f=0, flush_cnt 0→1.
- exec_start, then exec_done 4 cycles later -> EXEC_WAIT for 4 cycles with hold_f/d/e=1 and bubble_m=1. Holds drop on the done cycle, stall_cnt increases by 5.
- In EXEC_WAIT: mem_req=1, mem_ready=0 for 3 cycles, with exec_done pulsed in the 2nd -> MEM_WAIT for 3 cycles with all holds set and bubble_w=1. Then return to EXEC_WAIT, consume the pending done, and reach RUN the following cycle.
- MEM_TIMEOUT=4, mem_ready held 0 for 6 cycles -> mem_timeout_err=1 from the 5th cycle and stays set. After mem_ready=1, RUN resumes. Asserting resetn=0 clears the flag and both counters immediately.
